// File: rtl/lut_checker_if.sv
// rtl/lut_checker_if.sv - lut_checker bus: table config, run control, sample stream, results.
interface lut_checker_if #(
  parameter int IN_W  = 3,
  parameter int CNT_W = 16
);
  logic                 cfg_we;
  logic [IN_W-1:0]      cfg_addr;
  logic                 cfg_data;
  logic                 start;
  logic                 stop;
  logic                 clear;
  logic                 in_valid;
  logic [IN_W-1:0]      in_vec;
  logic                 in_r;
  logic                 running;
  logic                 mismatch;
  logic [CNT_W-1:0]     chk_cnt;
  logic [CNT_W-1:0]     err_cnt;
  logic                 first_vld;
  logic [IN_W-1:0]      first_vec;
  logic                 first_exp;
  logic                 first_got;
  logic [(1<<IN_W)-1:0] cov_map;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, stop, clear, in_valid, in_vec, in_r,
    input  running, mismatch, chk_cnt, err_cnt, first_vld, first_vec, first_exp,
           first_got, cov_map
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, stop, clear, in_valid, in_vec, in_r,
    output running, mismatch, chk_cnt, err_cnt, first_vld, first_vec, first_exp,
           first_got, cov_map
  );
endinterface

// File: rtl/lut_checker.sv
// rtl/lut_checker.sv - truth-table checker with CFG/RUN control, first-error capture, saturating counts.
// Optional coverage bitmap enabled by LUT_CHECKER_COVER_EN.
module lut_checker #(
  parameter int IN_W  = 3,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           aresetn,
  lut_checker_if.slave  bus
);
  localparam int DEPTH = 1 << IN_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {S_CFG = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [DEPTH-1:0] r_table;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_chk_cnt, r_err_cnt;
  logic             r_first_vld;
  logic [IN_W-1:0]  r_first_vec;
  logic             r_first_exp, r_first_got;
  logic             w_check, w_exp, w_miss;

  // clear drops any coincident sample; stop has priority over start
  always_comb begin
    w_state_nxt = r_state;
    w_check     = 1'b0;
    w_exp       = r_table[bus.in_vec];
    w_miss      = 1'b0;
    if (bus.stop)
      w_state_nxt = S_CFG;
    else if (r_state == S_CFG && bus.start)
      w_state_nxt = S_RUN;
    if (r_state == S_RUN && bus.in_valid && !bus.clear) begin
      w_check = 1'b1;
      w_miss  = (bus.in_r != w_exp);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_CFG;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      r_table <= '0;
    else if (r_state == S_CFG && bus.cfg_we)
      r_table[bus.cfg_addr] <= bus.cfg_data;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_mismatch  <= 1'b0;
      r_chk_cnt   <= '0;
      r_err_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_vec <= '0;
      r_first_exp <= 1'b0;
      r_first_got <= 1'b0;
    end else begin
      r_mismatch <= w_miss;
      if (bus.clear) begin
        r_chk_cnt   <= '0;
        r_err_cnt   <= '0;
        r_first_vld <= 1'b0;
        r_first_vec <= '0;
        r_first_exp <= 1'b0;
        r_first_got <= 1'b0;
      end else begin
        if (w_check && r_chk_cnt != CNT_MAX)
          r_chk_cnt <= r_chk_cnt + CNT_ONE;
        if (w_miss && r_err_cnt != CNT_MAX)
          r_err_cnt <= r_err_cnt + CNT_ONE;
        if (w_miss && !r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_vec <= bus.in_vec;
          r_first_exp <= w_exp;
          r_first_got <= bus.in_r;
        end
      end
    end
  end

`ifdef LUT_CHECKER_COVER_EN
  logic [DEPTH-1:0] r_cov_map;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      r_cov_map <= '0;
    else if (bus.clear)
      r_cov_map <= '0;
    else if (w_check)
      r_cov_map[bus.in_vec] <= 1'b1;
  end

  assign bus.cov_map = r_cov_map;
`else
  assign bus.cov_map = '0;
`endif

  assign bus.running   = (r_state == S_RUN);
  assign bus.mismatch  = r_mismatch;
  assign bus.chk_cnt   = r_chk_cnt;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.first_vld = r_first_vld;
  assign bus.first_vec = r_first_vec;
  assign bus.first_exp = r_first_exp;
  assign bus.first_got = r_first_got;
endmodule
